// File: rtl/rv32_id_stage_pv_if.sv
// Signal bundle between IF, register file, forwarding network, EX and the RV32 ID stage.
// The slave modport is the ID stage's view of the bundle; the master modport is the view of the logic around it.
interface rv32_id_stage_pv_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3
);
  logic                    if_valid_in;
  logic [XLEN-1:0]         pc_in;
  logic [31:0]             iw_in;
  logic                    id_ready_out;
  logic                    jump_enable_out;
  logic [XLEN-1:0]         jump_addr_out;
  logic [4:0]              regif_rs1_reg;
  logic [4:0]              regif_rs2_reg;
  logic [XLEN-1:0]         regif_rs1_data;
  logic [XLEN-1:0]         regif_rs2_data;
  logic [NUM_FWD-1:0]      fwd_enable;
  logic [5*NUM_FWD-1:0]    fwd_reg;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic [NUM_FWD-1:0]      fwd_is_load;
  logic                    ex_ready_in;
  logic                    ex_valid_out;
  logic [XLEN-1:0]         pc_out;
  logic [31:0]             iw_out;
  logic [XLEN-1:0]         rs1_data_out;
  logic [XLEN-1:0]         rs2_data_out;
  logic [4:0]              wb_reg_out;
  logic                    wb_enable_out;
  logic                    mem_read_out;
  logic                    mem_write_out;
  logic                    halted_out;

  modport slave (
    input  if_valid_in, pc_in, iw_in, regif_rs1_data, regif_rs2_data,
           fwd_enable, fwd_reg, fwd_data, fwd_is_load, ex_ready_in,
    output id_ready_out, jump_enable_out, jump_addr_out, regif_rs1_reg, regif_rs2_reg,
           ex_valid_out, pc_out, iw_out, rs1_data_out, rs2_data_out,
           wb_reg_out, wb_enable_out, mem_read_out, mem_write_out, halted_out
  );

  modport master (
    output if_valid_in, pc_in, iw_in, regif_rs1_data, regif_rs2_data,
           fwd_enable, fwd_reg, fwd_data, fwd_is_load, ex_ready_in,
    input  id_ready_out, jump_enable_out, jump_addr_out, regif_rs1_reg, regif_rs2_reg,
           ex_valid_out, pc_out, iw_out, rs1_data_out, rs2_data_out,
           wb_reg_out, wb_enable_out, mem_read_out, mem_write_out, halted_out
  );
endinterface

// File: rtl/rv32_id_stage_pv.sv
// RV32 instruction-decode stage: operand forwarding, ID-resolved jumps with one-cycle squash,
// load-use stall, EBREAK halt and valid/ready handshakes towards IF and EX.
module rv32_id_stage_pv #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter logic [31:0] NOP_IW  = 32'h00000013
) (
  input logic              clk,
  input logic              reset,
  rv32_id_stage_pv_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] EBREAK   = 32'h00100073;

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  state_t state, state_next;

  logic [31:0] iw;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic writes_rd, uses_rs1, uses_rs2, is_load, is_store, is_branch, is_jal, is_jalr, known;
  logic is_ebreak, load_use, branch_taken, jump_req, id_ready, fire, load_insn;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_b, imm_j, jalr_sum, target;
  logic unused_fwd_is_load;

  assign iw  = bus.iw_in;
  assign rd  = iw[11:7];
  assign f3  = iw[14:12];
  assign rs1 = iw[19:15];
  assign is_ebreak = (iw == EBREAK);
  assign unused_fwd_is_load = ^bus.fwd_is_load;

  always_comb begin
    {writes_rd, uses_rs1, uses_rs2, is_load, is_store, is_branch, is_jal, is_jalr, known} = '0;
    case (iw[6:0])
      OP_R:      {writes_rd, uses_rs1, uses_rs2, known} = '1;
      OP_IMM:    {writes_rd, uses_rs1, known} = '1;
      OP_LOAD:   {writes_rd, uses_rs1, is_load, known} = '1;
      OP_STORE:  {uses_rs1, uses_rs2, is_store, known} = '1;
      OP_BRANCH: {uses_rs1, uses_rs2, is_branch, known} = '1;
      OP_JAL:    {writes_rd, is_jal, known} = '1;
      OP_JALR:   {writes_rd, uses_rs1, is_jalr, known} = '1;
      OP_LUI, OP_AUIPC: {writes_rd, known} = '1;
      default: ;
    endcase
  end

  assign rs2 = uses_rs2 ? iw[24:20] : 5'd0;
  assign bus.regif_rs1_reg = rs1;
  assign bus.regif_rs2_reg = rs2;

  // Walk from the oldest source down so the nearest matching stage wins.
  always_comb begin
    rs1_val = bus.regif_rs1_data;
    rs2_val = bus.regif_rs2_data;
    for (int unsigned i = NUM_FWD; i > 0; i--) begin
      if (bus.fwd_enable[i-1] && bus.fwd_reg[5*(i-1) +: 5] == rs1)
        rs1_val = bus.fwd_data[XLEN*(i-1) +: XLEN];
      if (bus.fwd_enable[i-1] && bus.fwd_reg[5*(i-1) +: 5] == rs2)
        rs2_val = bus.fwd_data[XLEN*(i-1) +: XLEN];
    end
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  assign load_use = bus.if_valid_in && state == RUN && bus.fwd_enable[0] && bus.fwd_is_load[0]
                 && bus.fwd_reg[4:0] != 5'd0
                 && ((uses_rs1 && bus.fwd_reg[4:0] == rs1) || (uses_rs2 && bus.fwd_reg[4:0] == rs2));

  assign imm_i = {{(XLEN-12){iw[31]}}, iw[31:20]};
  assign imm_b = {{(XLEN-12){iw[31]}}, iw[7], iw[30:25], iw[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){iw[31]}}, iw[19:12], iw[20], iw[30:21], 1'b0};
  assign jalr_sum = rs1_val + imm_i;

  always_comb begin
    branch_taken = 1'b0;
    case (f3)
      3'b000: branch_taken = (rs1_val == rs2_val);
      3'b001: branch_taken = (rs1_val != rs2_val);
      3'b100: branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: branch_taken = (rs1_val <  rs2_val);
      3'b111: branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  assign jump_req = is_jal || is_jalr || (is_branch && branch_taken);
  assign target   = is_jal  ? bus.pc_in + imm_j
                  : is_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                  :           bus.pc_in + imm_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (fire && jump_req)       state_next = FLUSH;
        else if (fire && is_ebreak) state_next = HALT;
      end
      FLUSH:   if (bus.if_valid_in && id_ready) state_next = RUN;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    id_ready       = 1'b0;
    bus.halted_out = 1'b0;
    case (state)
      RUN:     id_ready = bus.ex_ready_in && !load_use;
      FLUSH:   id_ready = bus.ex_ready_in;
      HALT:    bus.halted_out = 1'b1;
      default: id_ready = 1'b0;
    endcase
  end

  assign bus.id_ready_out    = id_ready;
  assign fire                = bus.if_valid_in && id_ready && state == RUN;
  assign bus.jump_enable_out = fire && jump_req;
  assign bus.jump_addr_out   = bus.jump_enable_out ? target : '0;
  assign load_insn           = fire && known && !is_ebreak;

  // Anything accepted by EX that is not a decodable fired instruction becomes a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ex_valid_out  <= 1'b0;
      bus.pc_out        <= '0;
      bus.iw_out        <= NOP_IW;
      bus.rs1_data_out  <= '0;
      bus.rs2_data_out  <= '0;
      bus.wb_reg_out    <= '0;
      bus.wb_enable_out <= 1'b0;
      bus.mem_read_out  <= 1'b0;
      bus.mem_write_out <= 1'b0;
    end else if (bus.ex_ready_in) begin
      if (load_insn) begin
        bus.ex_valid_out  <= 1'b1;
        bus.pc_out        <= bus.pc_in;
        bus.iw_out        <= iw;
        bus.rs1_data_out  <= rs1_val;
        bus.rs2_data_out  <= rs2_val;
        bus.wb_reg_out    <= writes_rd ? rd : 5'd0;
        bus.wb_enable_out <= writes_rd && rd != 5'd0;
        bus.mem_read_out  <= is_load;
        bus.mem_write_out <= is_store;
      end else begin
        bus.ex_valid_out  <= 1'b0;
        bus.pc_out        <= '0;
        bus.iw_out        <= NOP_IW;
        bus.rs1_data_out  <= '0;
        bus.rs2_data_out  <= '0;
        bus.wb_reg_out    <= '0;
        bus.wb_enable_out <= 1'b0;
        bus.mem_read_out  <= 1'b0;
        bus.mem_write_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rv32_id_stage_pv.sv
// Directed self-checking bench for rv32_id_stage_pv: forwarding, branches/jumps with squash,
// load-use stall, EX back-pressure and EBREAK halt with reset recovery.
module tb_rv32_id_stage_pv;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst_n;
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_iw;

  rv32_id_stage_pv_if #(.XLEN(32), .NUM_FWD(3)) bus ();

  rv32_id_stage_pv #(.XLEN(32), .NUM_FWD(3), .NOP_IW(NOP)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.if_valid_in = 1'b0;  bus.pc_in = '0;  bus.iw_in = NOP;
    bus.regif_rs1_data = '0; bus.regif_rs2_data = '0;
    bus.fwd_enable = '0; bus.fwd_reg = '0; bus.fwd_data = '0; bus.fwd_is_load = '0;
    bus.ex_ready_in = 1'b1;
    #12;
    chk("reset_pc", bus.pc_out, 32'h0);
    chk("reset_iw", bus.iw_out, NOP);
    chk("reset_valid", {31'b0, bus.ex_valid_out}, 32'h0);
    chk("reset_halted", {31'b0, bus.halted_out}, 32'h0);
    chk("reset_wb_en", {31'b0, bus.wb_enable_out}, 32'h0);
    chk("reset_mem", {30'b0, bus.mem_read_out, bus.mem_write_out}, 32'h0);
    chk("reset_rs1", bus.rs1_data_out, 32'h0);
    rst_n = 1'b1;
    tick;

    // Forwarding priority: x5 in fwd[0], fwd[1] and the register file.
    bus.if_valid_in = 1'b1; bus.pc_in = 32'h40; bus.iw_in = enc_r(5'd6, 5'd5, 5'd5);
    bus.regif_rs1_data = 32'h33; bus.regif_rs2_data = 32'h33;
    bus.fwd_enable = 3'b011; bus.fwd_reg = {5'd0, 5'd5, 5'd5};
    bus.fwd_data = {32'h0, 32'h22, 32'h11};
    #1;
    chk("add_rs1_addr", {27'b0, bus.regif_rs1_reg}, 32'd5);
    chk("add_rs2_addr", {27'b0, bus.regif_rs2_reg}, 32'd5);
    chk("add_ready", {31'b0, bus.id_ready_out}, 32'h1);
    chk("add_no_jump", {31'b0, bus.jump_enable_out}, 32'h0);
    tick;
    chk("fwd0_rs1", bus.rs1_data_out, 32'h11);
    chk("fwd0_rs2", bus.rs2_data_out, 32'h11);
    chk("add_valid", {31'b0, bus.ex_valid_out}, 32'h1);
    chk("add_wb_reg", {27'b0, bus.wb_reg_out}, 32'd6);
    chk("add_wb_en", {31'b0, bus.wb_enable_out}, 32'h1);
    chk("add_pc", bus.pc_out, 32'h40);
    bus.fwd_enable = 3'b010;
    tick;
    chk("fwd1_rs1", bus.rs1_data_out, 32'h22);
    chk("fwd1_rs2", bus.rs2_data_out, 32'h22);
    bus.fwd_enable = 3'b000;
    tick;
    chk("regif_rs1", bus.rs1_data_out, 32'h33);

    // BEQ taken, squash of the following instruction, then BNE not taken.
    bus.pc_in = 32'h100; exp_iw = enc_b(3'b000, 5'd1, 5'd2, 13'd16); bus.iw_in = exp_iw;
    bus.regif_rs1_data = 32'd7; bus.regif_rs2_data = 32'd7;
    #1;
    chk("beq_jump", {31'b0, bus.jump_enable_out}, 32'h1);
    chk("beq_addr", bus.jump_addr_out, 32'h110);
    chk("beq_rs2_addr", {27'b0, bus.regif_rs2_reg}, 32'd2);
    tick;
    chk("beq_iw", bus.iw_out, exp_iw);
    chk("beq_valid", {31'b0, bus.ex_valid_out}, 32'h1);
    chk("beq_wb_en", {31'b0, bus.wb_enable_out}, 32'h0);
    bus.pc_in = 32'h104; bus.iw_in = enc_r(5'd6, 5'd5, 5'd5);
    #1;
    chk("flush_ready", {31'b0, bus.id_ready_out}, 32'h1);
    chk("flush_addr", bus.jump_addr_out, 32'h0);
    tick;
    chk("squash_iw", bus.iw_out, NOP);
    chk("squash_valid", {31'b0, bus.ex_valid_out}, 32'h0);
    bus.pc_in = 32'h110; bus.iw_in = enc_b(3'b001, 5'd1, 5'd2, 13'd16);
    #1;
    chk("bne_jump", {31'b0, bus.jump_enable_out}, 32'h0);
    tick;
    chk("bne_valid", {31'b0, bus.ex_valid_out}, 32'h1);

    // Signed vs unsigned compare: -1 vs 1.
    bus.regif_rs1_data = 32'hFFFF_FFFF; bus.regif_rs2_data = 32'd1;
    bus.pc_in = 32'h120; bus.iw_in = enc_b(3'b110, 5'd1, 5'd2, 13'd16);
    #1;
    chk("bltu_jump", {31'b0, bus.jump_enable_out}, 32'h0);
    tick;
    bus.pc_in = 32'h124; bus.iw_in = enc_b(3'b100, 5'd1, 5'd2, 13'd16);
    #1;
    chk("blt_jump", {31'b0, bus.jump_enable_out}, 32'h1);
    chk("blt_addr", bus.jump_addr_out, 32'h134);
    tick;
    // FLUSH waits for a valid IF cycle.
    bus.if_valid_in = 1'b0;
    #1;
    chk("flush_idle_ready", {31'b0, bus.id_ready_out}, 32'h1);
    tick;
    bus.if_valid_in = 1'b1; bus.pc_in = 32'h200; exp_iw = enc_r(5'd6, 5'd5, 5'd5); bus.iw_in = exp_iw;
    tick;
    chk("flush_held_iw", bus.iw_out, NOP);
    tick;
    chk("after_flush_iw", bus.iw_out, exp_iw);
    chk("after_flush_pc", bus.pc_out, 32'h200);

    // Load-use stall on x3, then forwarding once the load data arrives.
    bus.pc_in = 32'h204; bus.iw_in = enc_r(5'd4, 5'd3, 5'd0);
    bus.fwd_enable = 3'b001; bus.fwd_reg = {5'd0, 5'd0, 5'd3}; bus.fwd_is_load = 3'b001;
    bus.fwd_data = {32'h0, 32'h0, 32'h0000ABCD};
    bus.regif_rs1_data = 32'h33; bus.regif_rs2_data = 32'h55;
    #1;
    chk("lu_ready", {31'b0, bus.id_ready_out}, 32'h0);
    tick;
    chk("lu_bubble_valid", {31'b0, bus.ex_valid_out}, 32'h0);
    chk("lu_bubble_iw", bus.iw_out, NOP);
    bus.fwd_is_load = 3'b000;
    #1;
    chk("lu_clear_ready", {31'b0, bus.id_ready_out}, 32'h1);
    tick;
    chk("lu_rs1", bus.rs1_data_out, 32'h0000ABCD);
    chk("lu_rs2_x0", bus.rs2_data_out, 32'h0);
    chk("lu_wb_reg", {27'b0, bus.wb_reg_out}, 32'd4);
    chk("lu_valid", {31'b0, bus.ex_valid_out}, 32'h1);

    // JALR x1,8(x2): stalled first (stall beats jump), then resolves.
    bus.pc_in = 32'h300; bus.iw_in = enc_i(7'b1100111, 5'd1, 3'b000, 5'd2, 12'd8);
    bus.fwd_reg = {5'd0, 5'd0, 5'd2}; bus.fwd_is_load = 3'b001;
    bus.regif_rs1_data = 32'h1001;
    #1;
    chk("jalr_stall_jump", {31'b0, bus.jump_enable_out}, 32'h0);
    chk("jalr_stall_ready", {31'b0, bus.id_ready_out}, 32'h0);
    tick;
    bus.fwd_enable = 3'b000; bus.fwd_is_load = 3'b000;
    #1;
    chk("jalr_jump", {31'b0, bus.jump_enable_out}, 32'h1);
    chk("jalr_addr", bus.jump_addr_out, 32'h1008);
    tick;
    chk("jalr_wb_reg", {27'b0, bus.wb_reg_out}, 32'd1);
    chk("jalr_wb_en", {31'b0, bus.wb_enable_out}, 32'h1);
    bus.pc_in = 32'h1008; bus.iw_in = enc_r(5'd6, 5'd5, 5'd5);
    tick;
    chk("jalr_squash_valid", {31'b0, bus.ex_valid_out}, 32'h0);

    // JAL x0,-8: backward target, rd=x0 never writes back.
    bus.pc_in = 32'h400; bus.iw_in = enc_j(5'd0, 21'h1FFFF8);
    #1;
    chk("jal_addr", bus.jump_addr_out, 32'h3F8);
    tick;
    chk("jal_wb_en", {31'b0, bus.wb_enable_out}, 32'h0);
    bus.pc_in = 32'h3F8; bus.iw_in = enc_r(5'd6, 5'd5, 5'd5);
    tick;

    // Store and load decode.
    bus.pc_in = 32'h500; bus.iw_in = enc_s(5'd1, 5'd2, 12'd4);
    tick;
    chk("sw_mem_wr", {31'b0, bus.mem_write_out}, 32'h1);
    chk("sw_wb_en", {31'b0, bus.wb_enable_out}, 32'h0);
    bus.pc_in = 32'h504; exp_iw = enc_i(7'b0000011, 5'd7, 3'b010, 5'd1, 12'd0); bus.iw_in = exp_iw;
    tick;
    chk("lw_mem_rd", {31'b0, bus.mem_read_out}, 32'h1);
    chk("lw_wb_reg", {27'b0, bus.wb_reg_out}, 32'd7);

    // EX back-pressure for three cycles.
    bus.ex_ready_in = 1'b0; bus.pc_in = 32'h508; bus.iw_in = enc_r(5'd6, 5'd5, 5'd5);
    #1;
    chk("bp_ready", {31'b0, bus.id_ready_out}, 32'h0);
    repeat (3) tick;
    chk("bp_iw", bus.iw_out, exp_iw);
    chk("bp_pc", bus.pc_out, 32'h504);
    chk("bp_mem_rd", {31'b0, bus.mem_read_out}, 32'h1);
    bus.ex_ready_in = 1'b1;
    #1;
    chk("rel_ready", {31'b0, bus.id_ready_out}, 32'h1);
    tick;
    chk("rel_iw", bus.iw_out, enc_r(5'd6, 5'd5, 5'd5));
    chk("rel_pc", bus.pc_out, 32'h508);
    bus.if_valid_in = 1'b0;
    tick;
    chk("nodup_valid", {31'b0, bus.ex_valid_out}, 32'h0);

    // EBREAK halts; a taken branch is then ignored.
    bus.if_valid_in = 1'b1; bus.pc_in = 32'h600; bus.iw_in = 32'h00100073;
    tick;
    chk("halt_flag", {31'b0, bus.halted_out}, 32'h1);
    chk("ebreak_valid", {31'b0, bus.ex_valid_out}, 32'h0);
    chk("ebreak_iw", bus.iw_out, NOP);
    bus.pc_in = 32'h604; bus.iw_in = enc_b(3'b000, 5'd1, 5'd2, 13'd16);
    bus.regif_rs1_data = 32'd7; bus.regif_rs2_data = 32'd7;
    #1;
    chk("halt_ready", {31'b0, bus.id_ready_out}, 32'h0);
    chk("halt_jump", {31'b0, bus.jump_enable_out}, 32'h0);
    tick;
    chk("halt_valid", {31'b0, bus.ex_valid_out}, 32'h0);
    chk("halt_sticky", {31'b0, bus.halted_out}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_halted", {31'b0, bus.halted_out}, 32'h0);
    chk("rst_iw", bus.iw_out, NOP);
    chk("rst_valid", {31'b0, bus.ex_valid_out}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_jump", {31'b0, bus.jump_enable_out}, 32'h1);
    tick;
    chk("post_rst_valid", {31'b0, bus.ex_valid_out}, 32'h1);
    chk("post_rst_pc", bus.pc_out, 32'h604);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
